// File: rtl/avalon_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : avalon_io_responder_if
// Description : Avalon-MM bus bundle between the CPU data master and the
//               board I/O responder (command, wait and read-response signals).
// Revision    : 1.0 - initial release
// ============================================================================
interface avalon_io_responder_if #(
    parameter int ADDR_WIDTH = 29
);
    logic [ADDR_WIDTH-1:0] avs_address;
    logic [3:0]            avs_byteenable;
    logic                  avs_read;
    logic                  avs_write;
    logic [31:0]           avs_writedata;
    logic [31:0]           avs_readdata;
    logic                  avs_waitrequest;
    logic                  avs_readdatavalid;

    modport master (
        output avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest, avs_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/avalon_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : avalon_io_responder
// Description : Avalon-MM slave holding LED, HEX, scratch and error-count
//               registers, with programmable wait states and a fixed-latency
//               pipelined read response.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_io_responder #(
    parameter int ADDR_WIDTH   = 29,
    parameter int WAIT_STATES  = 1,
    parameter int READ_LATENCY = 2,
    parameter int HEX_DIGITS   = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    avalon_io_responder_if.slave      avs,
    output logic [9:0]                leds,
    output logic [7*HEX_DIGITS-1:0]   hex_segments,
    output logic [7:0]                error_count
);
    // Word addresses of the register map (byte address >> 2)
    localparam logic [ADDR_WIDTH-1:0] LED_WADDR = ADDR_WIDTH'(32'h0100_0000);
    localparam logic [ADDR_WIDTH-1:0] SCR_WADDR = ADDR_WIDTH'(32'h0100_0010);
    localparam logic [ADDR_WIDTH-1:0] HEX_WADDR = ADDR_WIDTH'(32'h0100_0020);
    localparam logic [ADDR_WIDTH-1:0] ERR_WADDR = ADDR_WIDTH'(32'h0100_0030);

    logic                  cmd;
    logic                  wait_req;
    logic                  accept;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  bad_acc;
    logic                  led_hit;
    logic                  scr_hit;
    logic                  err_hit;
    logic [HEX_DIGITS-1:0] hex_hit;
    logic                  mapped;
    logic [31:0]           rd_value;

    logic [9:0]  leds_q,    leds_d;
    logic [31:0] scratch_q, scratch_d;
    logic [6:0]  hex_q [HEX_DIGITS];
    logic [6:0]  hex_d [HEX_DIGITS];
    logic [7:0]  err_q,     err_d;

    logic [READ_LATENCY-1:0] pv_q, pv_d;
    logic [31:0]             pd_q [READ_LATENCY];
    logic [31:0]             pd_d [READ_LATENCY];

    // Byte-lane merge for full 32-bit registers
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Both read and write high is a write that is also flagged as an error
    assign cmd     = avs.avs_read | avs.avs_write;
    assign accept  = cmd & ~wait_req;
    assign wr_acc  = accept & avs.avs_write;
    assign rd_acc  = accept & avs.avs_read & ~avs.avs_write;
    assign bad_acc = accept & ((avs.avs_read & avs.avs_write) | ~mapped);

    assign avs.avs_waitrequest = wait_req;

    // Wait-state counter: holds off each command for WAIT_STATES cycles
    generate
        if (WAIT_STATES > 0) begin : g_wait
            localparam int WC_W = $clog2(WAIT_STATES + 1);
            logic [WC_W-1:0] wc_q, wc_d;

            assign wait_req = cmd && (wc_q < WC_W'(WAIT_STATES));

            // Count only while stalling; idle or acceptance returns to zero
            always_comb begin
                wc_d = '0;
                if (wait_req) wc_d = wc_q + 1'b1;
            end

            // Wait counter register
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) wc_q <= '0;
                else        wc_q <= wc_d;
            end
        end else begin : g_nowait
            assign wait_req = 1'b0;
        end
    endgenerate

    // Full-address decode and read-data mux
    always_comb begin
        led_hit  = (avs.avs_address == LED_WADDR);
        scr_hit  = (avs.avs_address == SCR_WADDR);
        err_hit  = (avs.avs_address == ERR_WADDR);
        hex_hit  = '0;
        rd_value = '0;
        for (int i = 0; i < HEX_DIGITS; i++) begin
            hex_hit[i] = (avs.avs_address == HEX_WADDR + ADDR_WIDTH'(i));
            if (hex_hit[i]) rd_value[6:0] = hex_q[i];
        end
        mapped = led_hit | scr_hit | err_hit | (|hex_hit);
        if (led_hit) rd_value[9:0] = leds_q;
        if (scr_hit) rd_value      = scratch_q;
        if (err_hit) rd_value[7:0] = err_q;
    end

    // Register writes per byte lane; ERRCNT write-clear beats the increment
    always_comb begin
        leds_d    = leds_q;
        scratch_d = scratch_q;
        hex_d     = hex_q;
        err_d     = err_q;
        if (wr_acc) begin
            if (led_hit) begin
                if (avs.avs_byteenable[0]) leds_d[7:0] = avs.avs_writedata[7:0];
                if (avs.avs_byteenable[1]) leds_d[9:8] = avs.avs_writedata[9:8];
            end
            if (scr_hit) begin
                scratch_d = merge_lanes(scratch_q, avs.avs_writedata, avs.avs_byteenable);
            end
            for (int i = 0; i < HEX_DIGITS; i++) begin
                if (hex_hit[i] && avs.avs_byteenable[0]) hex_d[i] = avs.avs_writedata[6:0];
            end
        end
        if (wr_acc && err_hit) begin
            err_d = 8'd0;
        end else if (bad_acc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Read pipeline: each stage only reloads when a response moves into it,
    // so the last stage holds the previous readdata between responses
    always_comb begin
        pv_d[0] = rd_acc;
        pd_d[0] = rd_acc ? rd_value : pd_q[0];
        for (int s = 1; s < READ_LATENCY; s++) begin
            pv_d[s] = pv_q[s-1];
            pd_d[s] = pv_q[s-1] ? pd_q[s-1] : pd_q[s];
        end
    end

    // Register file and read pipeline state; reset flushes in-flight reads
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leds_q    <= '0;
            scratch_q <= '0;
            err_q     <= '0;
            pv_q      <= '0;
            for (int i = 0; i < HEX_DIGITS; i++) hex_q[i] <= 7'h7F;
            for (int s = 0; s < READ_LATENCY; s++) pd_q[s] <= '0;
        end else begin
            leds_q    <= leds_d;
            scratch_q <= scratch_d;
            err_q     <= err_d;
            pv_q      <= pv_d;
            for (int i = 0; i < HEX_DIGITS; i++) hex_q[i] <= hex_d[i];
            for (int s = 0; s < READ_LATENCY; s++) pd_q[s] <= pd_d[s];
        end
    end

    assign avs.avs_readdatavalid = pv_q[READ_LATENCY-1];
    assign avs.avs_readdata      = pd_q[READ_LATENCY-1];
    assign leds                  = leds_q;
    assign error_count           = err_q;

    generate
        for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_hex_out
            assign hex_segments[7*i +: 7] = hex_q[i];
        end
    endgenerate
endmodule
`default_nettype wire

// File: doc/avalon_io_responder.md
Name: avalon_io_responder

Overview:
- Avalon-MM slave for the CPU main data port's external address window (word address bits above on-chip RAM non-zero).
- Holds LED, HEX-display, scratch and error-count registers.
- Inserts programmable wait states with waitrequest.
- Returns read data with fixed pipelined latency using readdatavalid.
- Drives board LED and 7-segment outputs directly.

Parameters:
ADDR_WIDTH, 29, word-address width of the Avalon port
WAIT_STATES, 1, cycles waitrequest is held high before each command is accepted (0 allowed)
READ_LATENCY, 2, cycles from read acceptance to readdatavalid (>=1)
HEX_DIGITS, 6, number of 7-segment digit registers (1..8)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
avs_address  input  ADDR_WIDTH  word address
avs_byteenable  input  4  byte lanes for writes
avs_read  input  1  read request
avs_write  input  1  write request
avs_writedata  input  32  write data
avs_readdata  output  32  read data, valid when avs_readdatavalid=1
avs_waitrequest  output  1  command not accepted this cycle
avs_readdatavalid  output  1  one-cycle pulse per accepted read
leds  output  10  LED register
hex_segments  output  7*HEX_DIGITS  digit i at bits [7i+6:7i], active-low segments
error_count  output  8  saturating count of bad accesses

Behaviour:
- Register map (byte address = word address << 2):
  - LED at 0x04000000: bits [9:0], rest read 0.
  - SCRATCH at 0x04000040: 32 bits.
  - HEX i at 0x04000080+4i for i<HEX_DIGITS: bits [6:0].
  - ERRCNT at 0x040000C0: bits [7:0], read-only; any accepted write clears it to 0.
- Decode compares the full ADDR_WIDTH word address.
- Reset (reset=0, asynchronous) sets:
  - leds=0, hex digits=7'h7F (blank), scratch=0, error_count=0.
  - avs_readdatavalid=0, avs_readdata=0.
  - Wait counter=0; read pipeline flushed (any in-flight read response is dropped, never emitted).
- Command = avs_read|avs_write.
- Wait states:
  - Counter wc increments on each cycle with command pending and avs_waitrequest=1.
  - avs_waitrequest = command && (wc < WAIT_STATES), combinational.
  - Acceptance cycle: command && !avs_waitrequest. wc returns to 0 at that edge.
  - No command: avs_waitrequest=0 and wc=0.
  - Master must hold address/data/controls stable while waitrequest=1.
- WAIT_STATES=0: every command accepted in its first cycle, so back-to-back accepts are allowed.
- Write acceptance: selected register updated at that edge, per byte lane under avs_byteenable. Unimplemented bits are ignored. byteenable=0 writes nothing but still counts as accepted.
- Read acceptance:
  - Register value is sampled at the acceptance edge into a READ_LATENCY-deep shift pipeline.
  - avs_readdatavalid=1 with that data exactly READ_LATENCY cycles after the acceptance edge, for one cycle.
  - Reads may be accepted on consecutive cycles; responses arrive in order, one per cycle.
  - When no response is due, avs_readdatavalid=0 and avs_readdata holds its last value.
- Read after write to the same register: a read accepted after the write's acceptance returns new data. A read already in the pipeline keeps its sampled value.
- Error cases: error_count increments by 1 per accepted bad access and saturates at 255.
  - Unmapped read: returns 32'h00000000 with normal latency and counts an error.
  - Unmapped write: ignored and counts an error.
  - read and write both high: treated as a write only; no read response is generated; counts an error.
- Write to ERRCNT: clears to 0 and takes priority over any increment in the same cycle.

Test Plan:
- Reset release, WAIT_STATES=1, READ_LATENCY=2: read LED -> waitrequest high 1 cycle, accept next cycle, readdatavalid 2 cycles later with 0x00000000; hex_segments all 1s.
- Write 0x04000000 data 0xFFFFFFFF be=4'b0001, then read -> leds=10'h0FF, readdata=0x000000FF.
- WAIT_STATES=0: four back-to-back reads of SCRATCH (preloaded 0xCAFEF00D) -> four consecutive readdatavalid pulses, each 0xCAFEF00D, starting 2 cycles after the first accept.
- Read of 0x04000200 then write 0x04000204 -> readdata 0, error_count=2; write ERRCNT -> error_count=0; 260 bad accesses -> error_count=255.
- Read accepted, then reset asserted for 1 cycle before response -> no readdatavalid pulse after reset; all registers at reset values.
- Write HEX2 0x00000040 -> hex_segments[20:14]=7'h40, other digits 7'h7F; read and write high together -> no readdatavalid, error_count+1.
